// File: rtl/cvxif_pkg.sv
// cvxif_pkg: shared types and constants for the CVXIF offload master
//   XLEN           default register/data width
//   OPCODE_CUSTOM3 major opcode of offloaded instructions
//   state_e        master FSM states
//   resp_t         response record returned to the core
package cvxif_pkg;
   localparam int XLEN = 32;
   localparam logic [6:0] OPCODE_CUSTOM3 = 7'b1111011;
   typedef enum logic [2:0] {IDLE, ISSUE, REGS, WAIT_RESULT, RESP} state_e;
   typedef struct packed {
      logic            we;
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
      logic            illegal;
      logic            timeout;
   } resp_t;
   function automatic logic is_custom3(input logic [31:0] instr);
      return instr[6:0] == OPCODE_CUSTOM3;
   endfunction
endpackage

// File: rtl/cvxif_timeout_ctr.sv
// cvxif_timeout_ctr: saturating wait counter for the result phase
//   clk, rst  clock and synchronous active-high reset
//   clear     restart counting from zero
//   en        one waiting cycle elapses
//   expired   this waiting cycle is the LIMIT-th one (never when LIMIT = 0)
module cvxif_timeout_ctr #(
   parameter int LIMIT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic expired
);
   localparam int W = LIMIT > 0 ? $clog2(LIMIT + 1) : 1;
   logic [W-1:0] count;
   always_ff @(posedge clk)
      if (rst || clear) count <= '0;
      else if (en) count <= (count == W'(LIMIT)) ? count : count + W'(1);
   // flagged one count early so the FSM leaves on the LIMIT-th waiting cycle
   assign expired = en && LIMIT != 0 && count == W'(LIMIT - 1);
endmodule

// File: rtl/cvxif_offload_master.sv
// cvxif_offload_master: core-side CVXIF initiator, one transaction in flight
//   cpu_req_*   instruction + operands from the core (taken in IDLE)
//   cpu_resp_*  writeback / illegal / timeout response to the core
//   issue_*     instruction offer and accept decision from the coprocessor
//   register_*  operand transfer to the coprocessor
//   result_*    result collection from the coprocessor
module cvxif_offload_master
   import cvxif_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int XLEN = cvxif_pkg::XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cpu_req_valid,
   output logic            cpu_req_ready,
   input  logic [31:0]     cpu_req_instr,
   input  logic [XLEN-1:0] cpu_req_rs1,
   input  logic [XLEN-1:0] cpu_req_rs2,
   output logic            cpu_resp_valid,
   input  logic            cpu_resp_ready,
   output logic            cpu_resp_we,
   output logic [4:0]      cpu_resp_rd,
   output logic [XLEN-1:0] cpu_resp_data,
   output logic            cpu_resp_illegal,
   output logic            cpu_resp_timeout,
   output logic            issue_valid,
   input  logic            issue_ready,
   output logic [31:0]     issue_req_instr,
   input  logic            issue_resp_accept,
   input  logic            issue_resp_writeback,
   input  logic [1:0]      issue_resp_register_read,
   output logic            register_valid,
   input  logic            register_ready,
   output logic [XLEN-1:0] register_rs [0:1],
   output logic [1:0]      register_rs_valid,
   input  logic            result_valid,
   output logic            result_ready,
   input  logic [XLEN-1:0] result_data
);
   state_e          state, state_nx;
   logic [31:0]     instr;
   logic [XLEN-1:0] rs1, rs2;
   logic            wb;
   logic [1:0]      mask;
   resp_t           resp;
   logic            expired;

   cvxif_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_ctr (
      .clk(clk),
      .rst(rst),
      .clear(state != WAIT_RESULT),
      .en(state == WAIT_RESULT),
      .expired(expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         instr <= '0;
         rs1   <= '0;
         rs2   <= '0;
         wb    <= 1'b0;
         mask  <= 2'b00;
         resp  <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && cpu_req_valid) begin
            instr   <= cpu_req_instr;
            rs1     <= cpu_req_rs1;
            rs2     <= cpu_req_rs2;
            resp.rd <= cpu_req_instr[11:7];
         end
         if (state == ISSUE && issue_ready) begin
            wb           <= issue_resp_writeback;
            mask         <= issue_resp_accept ? issue_resp_register_read : 2'b00;
            resp.illegal <= !issue_resp_accept;
         end
         // a result arriving on the expiry cycle still wins over the timeout
         if (state == WAIT_RESULT && result_valid) begin
            resp.we   <= 1'b1;
            resp.data <= result_data;
         end else if (expired) resp.timeout <= 1'b1;
         if (state == RESP && cpu_resp_ready) resp <= '0;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:        state_nx = cpu_req_valid ? ISSUE : IDLE;
         ISSUE:       state_nx = !issue_ready ? ISSUE : issue_resp_accept ? REGS : RESP;
         REGS:        state_nx = !register_ready ? REGS : wb ? WAIT_RESULT : RESP;
         WAIT_RESULT: state_nx = (result_valid || expired) ? RESP : WAIT_RESULT;
         RESP:        state_nx = cpu_resp_ready ? IDLE : RESP;
         default:     state_nx = IDLE;
      endcase
   end

   // req_ready is masked during reset so every handshake output reads 0 then
   assign cpu_req_ready     = state == IDLE && !rst;
   assign cpu_resp_valid    = state == RESP;
   assign cpu_resp_we       = resp.we;
   assign cpu_resp_rd       = resp.rd;
   assign cpu_resp_data     = resp.data;
   assign cpu_resp_illegal  = resp.illegal;
   assign cpu_resp_timeout  = resp.timeout;
   assign issue_valid       = state == ISSUE;
   assign issue_req_instr   = instr;
   assign register_valid    = state == REGS;
   assign register_rs[0]    = rs1;
   assign register_rs[1]    = rs2;
   assign register_rs_valid = mask;
   assign result_ready      = state == WAIT_RESULT;
endmodule

// File: tb/tb_cvxif_offload_master.sv
// tb_cvxif_offload_master: scoreboard bench for the CVXIF offload master
module tb_cvxif_offload_master;
   import cvxif_pkg::*;
   localparam int TO = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic            cpu_req_valid, cpu_req_ready;
   logic [31:0]     cpu_req_instr;
   logic [XLEN-1:0] cpu_req_rs1, cpu_req_rs2;
   logic            cpu_resp_valid, cpu_resp_ready, cpu_resp_we;
   logic [4:0]      cpu_resp_rd;
   logic [XLEN-1:0] cpu_resp_data;
   logic            cpu_resp_illegal, cpu_resp_timeout;
   logic            issue_valid, issue_ready;
   logic [31:0]     issue_req_instr;
   logic            issue_resp_accept, issue_resp_writeback;
   logic [1:0]      issue_resp_register_read;
   logic            register_valid, register_ready;
   logic [XLEN-1:0] register_rs [0:1];
   logic [1:0]      register_rs_valid;
   logic            result_valid, result_ready;
   logic [XLEN-1:0] result_data;

   always #5 clk = ~clk;

   cvxif_offload_master #(.TIMEOUT_CYCLES(TO), .XLEN(XLEN)) dut (
      .clk(clk), .rst(rst),
      .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
      .cpu_req_instr(cpu_req_instr), .cpu_req_rs1(cpu_req_rs1), .cpu_req_rs2(cpu_req_rs2),
      .cpu_resp_valid(cpu_resp_valid), .cpu_resp_ready(cpu_resp_ready),
      .cpu_resp_we(cpu_resp_we), .cpu_resp_rd(cpu_resp_rd), .cpu_resp_data(cpu_resp_data),
      .cpu_resp_illegal(cpu_resp_illegal), .cpu_resp_timeout(cpu_resp_timeout),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_req_instr(issue_req_instr),
      .issue_resp_accept(issue_resp_accept), .issue_resp_writeback(issue_resp_writeback),
      .issue_resp_register_read(issue_resp_register_read),
      .register_valid(register_valid), .register_ready(register_ready),
      .register_rs(register_rs), .register_rs_valid(register_rs_valid),
      .result_valid(result_valid), .result_ready(result_ready), .result_data(result_data)
   );

   int    checks = 0, errors = 0;
   resp_t sb[$];
   resp_t obs, exp_r;
   logic [1:0] obs_mask;
   logic  reg_seen, got;
   int    n_issue, n_reg, n_res, t_wait, t_resp, unstable;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      cpu_req_valid = 0; cpu_req_instr = '0; cpu_req_rs1 = '0; cpu_req_rs2 = '0;
      cpu_resp_ready = 0; issue_ready = 0; issue_resp_accept = 0; issue_resp_writeback = 0;
      issue_resp_register_read = 2'b00; register_ready = 0; result_valid = 0; result_data = '0;
   endtask

   function automatic logic [31:0] mk(input logic [4:0] rd, input logic [6:0] f7);
      return {f7, 5'd2, 5'd1, 3'd0, rd, OPCODE_CUSTOM3};
   endfunction

   function automatic resp_t cur_resp();
      return '{we: cpu_resp_we, rd: cpu_resp_rd, data: cpu_resp_data,
               illegal: cpu_resp_illegal, timeout: cpu_resp_timeout};
   endfunction

   // handshake flags plus an OR of every data output
   function automatic logic [10:0] outs_v();
      return {cpu_req_ready, cpu_resp_valid, cpu_resp_we, cpu_resp_illegal, cpu_resp_timeout,
              issue_valid, register_valid, result_ready, register_rs_valid,
              |{cpu_resp_rd, cpu_resp_data, issue_req_instr, register_rs[0], register_rs[1]}};
   endfunction

   // Peer model: iw/rw/pw = cycles ready is held low, dw = result delay (-1 = never)
   task automatic drive_txn(input logic [31:0] ins, input logic [XLEN-1:0] a, b,
                            input logic acc, wbk, input logic [1:0] msk,
                            input logic [XLEN-1:0] res, input int iw, rw, dw, pw);
      int ic = 0, rc = 0, wc = 0, pc = 0;
      obs = '0; obs_mask = 2'b00; reg_seen = 0; got = 0;
      n_issue = 0; n_reg = 0; n_res = 0; t_wait = -1; t_resp = -1; unstable = 0;
      cpu_req_valid = 1; cpu_req_instr = ins; cpu_req_rs1 = a; cpu_req_rs2 = b;
      for (int cyc = 0; cyc < 200 && !got; cyc++) begin
         if (cyc == 1) cpu_req_valid = 0;
         issue_ready = issue_valid && ic >= iw;
         issue_resp_accept = acc; issue_resp_writeback = wbk; issue_resp_register_read = msk;
         if (issue_valid) begin
            if (issue_req_instr !== ins) unstable++;
            ic++; n_issue += int'(issue_ready);
         end
         register_ready = register_valid && rc >= rw;
         if (register_valid) begin
            reg_seen = 1; obs_mask = register_rs_valid;
            if (register_rs[0] !== a || register_rs[1] !== b) unstable++;
            rc++; n_reg += int'(register_ready);
         end
         result_valid = result_ready && dw >= 0 && wc >= dw;
         result_data = res;
         if (result_ready) begin
            if (t_wait < 0) t_wait = cyc;
            wc++; n_res += int'(result_valid);
         end
         cpu_resp_ready = cpu_resp_valid && pc >= pw;
         if (cpu_resp_valid) begin
            if (t_resp < 0) begin
               t_resp = cyc; obs = cur_resp();
            end else if (cur_resp() !== obs) unstable++;
            pc++; got = cpu_resp_ready;
         end
         step();
      end
      idle_inputs();
      checks++;
      if (!got) begin
         errors++; $display("FAIL txn_bound response handshake got 0 want 1 within 200 cycles");
      end
   endtask

   task automatic test_reset;
      rst = 1; step(); step();
      checks++;
      if (outs_v() !== 11'd0) begin errors++; $display("FAIL reset_outs got %b want 0", outs_v()); end
      rst = 0; step();
      checks++;
      if (outs_v() !== 11'b100_0000_0000) begin errors++; $display("FAIL reset_idle got %b want 10000000000", outs_v()); end
   endtask

   task automatic test_add;
      sb.push_back('{we: 1'b1, rd: 5'd5, data: 32'h3, illegal: 1'b0, timeout: 1'b0});
      drive_txn(mk(5'd5, 7'd0), 32'd1, 32'd2, 1, 1, 2'b11, 32'h3, 0, 0, 2, 0);
      exp_r = sb.pop_front();
      checks++;
      if (obs !== exp_r) begin errors++; $display("FAIL add_resp got %h want %h", obs, exp_r); end
      checks++;
      if (obs_mask !== 2'b11) begin errors++; $display("FAIL add_mask got %b want 11", obs_mask); end
      checks++;
      if ({cpu_req_ready, cpu_resp_valid, cpu_resp_we} !== 3'b100) begin
         errors++; $display("FAIL add_after got %b want 100", {cpu_req_ready, cpu_resp_valid, cpu_resp_we});
      end
   endtask

   task automatic test_latency;
      sb.push_back('{we: 1'b1, rd: 5'd1, data: 32'hCAFE_0001, illegal: 1'b0, timeout: 1'b0});
      drive_txn(mk(5'd1, 7'd3), 32'd7, 32'd8, 1, 1, 2'b10, 32'hCAFE_0001, 0, 0, 0, 0);
      exp_r = sb.pop_front();
      checks++;
      if (obs !== exp_r) begin errors++; $display("FAIL lat_resp got %h want %h", obs, exp_r); end
      checks++;
      if (t_resp !== 4) begin errors++; $display("FAIL latency got %0d want 4", t_resp); end
   endtask

   task automatic test_conj;
      sb.push_back('{we: 1'b1, rd: 5'd17, data: 32'h8765_4321, illegal: 1'b0, timeout: 1'b0});
      drive_txn(mk(5'd17, 7'd1), 32'h1234_5678, 32'hFFFF_0000, 1, 1, 2'b01, 32'h8765_4321, 0, 0, 0, 0);
      exp_r = sb.pop_front();
      checks++;
      if (obs !== exp_r) begin errors++; $display("FAIL conj_resp got %h want %h", obs, exp_r); end
      checks++;
      if (obs_mask !== 2'b01) begin errors++; $display("FAIL conj_mask got %b want 01", obs_mask); end
   endtask

   task automatic test_illegal;
      sb.push_back('{we: 1'b0, rd: 5'd12, data: '0, illegal: 1'b1, timeout: 1'b0});
      drive_txn(mk(5'd12, 7'd9), 32'd4, 32'd5, 0, 1, 2'b11, 32'h55, 0, 0, 0, 0);
      exp_r = sb.pop_front();
      checks++;
      if (obs !== exp_r) begin errors++; $display("FAIL ill_resp got %h want %h", obs, exp_r); end
      checks++;
      if (reg_seen !== 1'b0 || t_wait != -1) begin
         errors++; $display("FAIL ill_noregs got reg_seen=%b t_wait=%0d want 0/-1", reg_seen, t_wait);
      end
      checks++;
      if (t_resp !== 2) begin errors++; $display("FAIL ill_latency got %0d want 2", t_resp); end
   endtask

   task automatic test_no_writeback;
      sb.push_back('{we: 1'b0, rd: 5'd3, data: '0, illegal: 1'b0, timeout: 1'b0});
      drive_txn(mk(5'd3, 7'd2), 32'd9, 32'd10, 1, 0, 2'b00, 32'h77, 0, 0, 0, 0);
      exp_r = sb.pop_front();
      checks++;
      if (obs !== exp_r) begin errors++; $display("FAIL nowb_resp got %h want %h", obs, exp_r); end
      checks++;
      if (n_reg !== 1 || obs_mask !== 2'b00 || t_wait != -1) begin
         errors++; $display("FAIL nowb_regs got n_reg=%0d mask=%b t_wait=%0d want 1/00/-1", n_reg, obs_mask, t_wait);
      end
   endtask

   task automatic test_timeout;
      sb.push_back('{we: 1'b0, rd: 5'd20, data: '0, illegal: 1'b0, timeout: 1'b1});
      drive_txn(mk(5'd20, 7'd0), 32'd1, 32'd1, 1, 1, 2'b11, 32'h99, 0, 0, -1, 0);
      exp_r = sb.pop_front();
      checks++;
      if (obs !== exp_r) begin errors++; $display("FAIL to_resp got %h want %h", obs, exp_r); end
      checks++;
      if (t_resp - t_wait !== TO) begin errors++; $display("FAIL to_cycles got %0d want %0d", t_resp - t_wait, TO); end
      sb.push_back('{we: 1'b1, rd: 5'd21, data: 32'h0BAD_F00D, illegal: 1'b0, timeout: 1'b0});
      drive_txn(mk(5'd21, 7'd0), 32'd1, 32'd1, 1, 1, 2'b11, 32'h0BAD_F00D, 0, 0, TO - 1, 0);
      exp_r = sb.pop_front();
      checks++;
      if (obs !== exp_r) begin errors++; $display("FAIL to_last_resp got %h want %h", obs, exp_r); end
      checks++;
      if (t_resp - t_wait !== TO) begin errors++; $display("FAIL to_last_cycles got %0d want %0d", t_resp - t_wait, TO); end
   endtask

   task automatic test_backpressure;
      sb.push_back('{we: 1'b1, rd: 5'd30, data: 32'h1357_9BDF, illegal: 1'b0, timeout: 1'b0});
      drive_txn(mk(5'd30, 7'd5), 32'hAAAA_5555, 32'h5555_AAAA, 1, 1, 2'b10, 32'h1357_9BDF, 5, 5, 0, 5);
      exp_r = sb.pop_front();
      checks++;
      if (obs !== exp_r) begin errors++; $display("FAIL bp_resp got %h want %h", obs, exp_r); end
      checks++;
      if (unstable !== 0) begin errors++; $display("FAIL bp_stable got %0d changes want 0", unstable); end
      checks++;
      if ({n_issue, n_reg, n_res} !== {32'd1, 32'd1, 32'd1}) begin
         errors++; $display("FAIL bp_handshakes got %0d/%0d/%0d want 1/1/1", n_issue, n_reg, n_res);
      end
      checks++;
      if (t_resp !== 14) begin errors++; $display("FAIL bp_latency got %0d want 14", t_resp); end
   endtask

   task automatic test_back_to_back;
      sb.push_back('{we: 1'b1, rd: 5'd6, data: 32'h0000_0011, illegal: 1'b0, timeout: 1'b0});
      sb.push_back('{we: 1'b1, rd: 5'd7, data: 32'h0000_0022, illegal: 1'b0, timeout: 1'b0});
      drive_txn(mk(5'd6, 7'd0), 32'd11, 32'd12, 1, 1, 2'b11, 32'h11, 0, 0, 0, 0);
      exp_r = sb.pop_front();
      checks++;
      if (obs !== exp_r) begin errors++; $display("FAIL b2b_first got %h want %h", obs, exp_r); end
      drive_txn(mk(5'd7, 7'd0), 32'd21, 32'd22, 1, 1, 2'b11, 32'h22, 0, 0, 0, 0);
      exp_r = sb.pop_front();
      checks++;
      if (obs !== exp_r || t_resp !== 4) begin
         errors++; $display("FAIL b2b_second got %h lat %0d want %h lat 4", obs, t_resp, exp_r);
      end
   endtask

   task automatic test_reset_mid;
      for (int k = 0; k < 2; k++) begin
         cpu_req_valid = 1; cpu_req_instr = mk(5'd9, 7'd0); cpu_req_rs1 = 32'd3; cpu_req_rs2 = 32'd4;
         step();
         cpu_req_valid = 0; issue_ready = 1; issue_resp_accept = 1;
         issue_resp_writeback = 1; issue_resp_register_read = 2'b11;
         step();
         issue_ready = 0;
         if (k == 1) begin
            register_ready = 1; step(); register_ready = 0;
         end
         checks++;
         if ((k == 0 ? register_valid : result_ready) !== 1'b1) begin
            errors++; $display("FAIL rstmid_reach%0d got 0 want 1", k);
         end
         rst = 1; step();
         checks++;
         if (outs_v() !== 11'd0) begin errors++; $display("FAIL rstmid_outs%0d got %b want 0", k, outs_v()); end
         rst = 0; step();
         checks++;
         if (outs_v() !== 11'b100_0000_0000) begin
            errors++; $display("FAIL rstmid_idle%0d got %b want 10000000000", k, outs_v());
         end
      end
      sb.push_back('{we: 1'b1, rd: 5'd9, data: 32'h4242_4242, illegal: 1'b0, timeout: 1'b0});
      drive_txn(mk(5'd9, 7'd0), 32'd3, 32'd4, 1, 1, 2'b11, 32'h4242_4242, 0, 0, 1, 0);
      exp_r = sb.pop_front();
      checks++;
      if (obs !== exp_r) begin errors++; $display("FAIL rstmid_new got %h want %h", obs, exp_r); end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_add();
      test_latency();
      test_conj();
      test_illegal();
      test_no_writeback();
      test_timeout();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
